// File: rtl/fifo_tx_drain.sv
// rtl/fifo_tx_drain.sv - drains a byte FIFO into a byte transmitter, optionally appending LF after CR
module fifo_tx_drain #(
    parameter int          ADD_LF      = 1,
    parameter int          BUSY_TO     = 16,
    // byte_cnt value loaded on reset; 0 for normal use, non-zero only to reach the wrap point quickly
    parameter logic [15:0] CNT_PRELOAD = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    input  logic        tx_busy,
    output logic        read_en,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    output logic [15:0] byte_cnt,
    output logic        active
);

    localparam int             TO_W    = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TO - 1);
    localparam logic [7:0]     CR      = 8'h0D;
    localparam logic [7:0]     LF      = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        CAPTURE,
        SEND,
        WAIT_HI,
        WAIT_LO,
        INSERT
    } state_t;

    state_t          state;
    logic            lf_sent;
    logic            armed;
    logic [TO_W-1:0] to_cnt;

    // The pop strobe is gated by fifo_empty in the same cycle so an empty FIFO is never popped,
    // even if it drained between the IDLE decision and the POP cycle.
    assign read_en = (state == POP) && !fifo_empty;

    // Drain sequencer: one byte in flight at a time, with registered tx_send/active/tx_data/byte_cnt.
    // armed holds off the first pop until the second clock edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tx_data  <= 8'h00;
            tx_send  <= 1'b0;
            byte_cnt <= CNT_PRELOAD;
            active   <= 1'b0;
            lf_sent  <= 1'b0;
            to_cnt   <= '0;
            armed    <= 1'b0;
        end else begin
            armed   <= 1'b1;
            tx_send <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (armed && enable && !fifo_empty && !tx_busy) begin
                        state  <= POP;
                        active <= 1'b1;
                    end
                end
                POP: begin
                    if (fifo_empty) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    tx_data <= fifo_data;
                    tx_send <= 1'b1;
                    state   <= SEND;
                end
                SEND: begin
                    byte_cnt <= byte_cnt + 16'd1;
                    to_cnt   <= '0;
                    state    <= WAIT_HI;
                end
                WAIT_HI: begin
                    // A transmitter that never raises busy must not stall the drain forever.
                    if (tx_busy || (to_cnt == TO_LAST)) begin
                        to_cnt <= '0;
                        state  <= WAIT_LO;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if ((ADD_LF != 0) && (tx_data == CR) && !lf_sent) begin
                            state <= INSERT;
                        end else begin
                            lf_sent <= 1'b0;
                            active  <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                INSERT: begin
                    tx_data <= LF;
                    lf_sent <= 1'b1;
                    tx_send <= 1'b1;
                    state   <= SEND;
                end
                default: begin
                    active <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_tx_drain.sv
// tb/tb_fifo_tx_drain.sv - randomized self-checking bench for fifo_tx_drain
module tb_fifo_tx_drain;

    localparam int BUSY_TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic        enable     [2];
    logic        fifo_empty [2];
    logic [7:0]  fifo_data  [2] = '{8'h00, 8'h00};
    logic        tx_busy    [2];
    logic        read_en    [2];
    logic [7:0]  tx_data    [2];
    logic        tx_send    [2];
    logic [15:0] byte_cnt   [2];
    logic        active     [2];

    // instance 0: ADD_LF=1, count from 0; instance 1: ADD_LF=0, count preloaded near wrap
    for (genvar g = 0; g < 2; g++) begin : env
        fifo_tx_drain #(
            .ADD_LF     (g == 0 ? 1 : 0),
            .BUSY_TO    (BUSY_TO),
            .CNT_PRELOAD(g == 0 ? 16'h0000 : 16'hFFFE)
        ) dut (
            .clk       (clk),
            .reset     (rst_n),
            .enable    (enable[g]),
            .fifo_empty(fifo_empty[g]),
            .fifo_data (fifo_data[g]),
            .tx_busy   (tx_busy[g]),
            .read_en   (read_en[g]),
            .tx_data   (tx_data[g]),
            .tx_send   (tx_send[g]),
            .byte_cnt  (byte_cnt[g]),
            .active    (active[g])
        );
    end

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // FIFO and transmitter models
    logic [7:0] mem [2][256];
    int wr [2] = '{0, 0};
    int rd [2] = '{0, 0};
    int busy_len [2] = '{10, 10};
    int busy_cnt [2] = '{0, 0};

    // monitor logs
    int n_pop [2] = '{0, 0};
    int n_sent [2] = '{0, 0};
    int viol [2] = '{0, 0};
    int last_pop [2] = '{-1, -1};
    int last_gap [2] = '{0, 0};
    int min_gap [2] = '{1000, 1000};
    logic [7:0] sent [2][1024];

    // reference model: expected byte stream and byte count
    logic [7:0]  exp_q [$];
    logic [15:0] exp_cnt [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            fifo_empty[i] = (rd[i] == wr[i]);
            tx_busy[i]    = (busy_cnt[i] != 0);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (read_en[i]) begin
                fifo_data[i] <= mem[i][rd[i] & 255];
                rd[i] <= rd[i] + 1;
            end
            if (tx_send[i] && busy_len[i] > 0) busy_cnt[i] <= busy_len[i];
            else if (busy_cnt[i] > 0) busy_cnt[i] <= busy_cnt[i] - 1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (read_en[i]) begin
                if (fifo_empty[i]) viol[i]++;
                if (last_pop[i] >= 0) begin
                    last_gap[i] = cyc - last_pop[i];
                    if (last_gap[i] < min_gap[i]) min_gap[i] = last_gap[i];
                end
                last_pop[i] = cyc;
                n_pop[i]++;
            end
            if (tx_send[i]) begin
                sent[i][n_sent[i] % 1024] = tx_data[i];
                n_sent[i]++;
            end
        end
    end

    task automatic feed(input int i, input logic [7:0] b);
        mem[i][wr[i] & 255] = b;
        wr[i] = wr[i] + 1;
        exp_q.push_back(b);
        exp_cnt[i] = exp_cnt[i] + 16'd1;
        if (i == 0 && b == 8'h0D) begin
            exp_q.push_back(8'h0A);
            exp_cnt[i] = exp_cnt[i] + 16'd1;
        end
    endtask

    task automatic drain(input int i, input int budget, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!(fifo_empty[i] && !active[i] && !tx_busy[i]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (n < budget);
    endtask

    function automatic int seq_diff(input int i, input int base);
        int bad = 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (sent[i][(base + k) % 1024] !== exp_q[k]) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        enable[0] = 1'b0;
        enable[1] = 1'b0;
        exp_cnt[0] = 16'h0000;
        exp_cnt[1] = 16'hFFFE;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++; if (read_en[i] !== 1'b0) begin errors++; $display("FAIL reset_read_en[%0d] got %b want 0", i, read_en[i]); end
            checks++; if (tx_send[i] !== 1'b0) begin errors++; $display("FAIL reset_tx_send[%0d] got %b want 0", i, tx_send[i]); end
            checks++; if (tx_data[i] !== 8'h00) begin errors++; $display("FAIL reset_tx_data[%0d] got %h want 00", i, tx_data[i]); end
            checks++; if (byte_cnt[i] !== exp_cnt[i]) begin errors++; $display("FAIL reset_byte_cnt[%0d] got %h want %h", i, byte_cnt[i], exp_cnt[i]); end
            checks++; if (active[i] !== 1'b0) begin errors++; $display("FAIL reset_active[%0d] got %b want 0", i, active[i]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty();
        int p0 = n_pop[0];
        int p1 = n_pop[1];
        enable[0] = 1'b1;
        enable[1] = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (n_pop[0] - p0 !== 0) begin errors++; $display("FAIL empty_pops0 got %0d want 0", n_pop[0] - p0); end
        checks++; if (n_pop[1] - p1 !== 0) begin errors++; $display("FAIL empty_pops1 got %0d want 0", n_pop[1] - p1); end
        checks++; if (active[0] !== 1'b0) begin errors++; $display("FAIL empty_active got %b want 0", active[0]); end
    endtask

    task automatic test_single_byte();
        int bs = n_sent[0];
        int bp = n_pop[0];
        bit ok;
        exp_q.delete();
        busy_len[0] = 10;
        feed(0, 8'h41);
        drain(0, 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_done got timeout want idle"); end
        checks++; if (n_pop[0] - bp !== 1) begin errors++; $display("FAIL single_pops got %0d want 1", n_pop[0] - bp); end
        checks++; if (n_sent[0] - bs !== 1) begin errors++; $display("FAIL single_sends got %0d want 1", n_sent[0] - bs); end
        checks++; if (seq_diff(0, bs) !== 0) begin errors++; $display("FAIL single_data got %h want 41", sent[0][bs % 1024]); end
        checks++; if (byte_cnt[0] !== exp_cnt[0]) begin errors++; $display("FAIL single_cnt got %h want %h", byte_cnt[0], exp_cnt[0]); end
    endtask

    task automatic test_cr_insert();
        int bs = n_sent[0];
        int bp = n_pop[0];
        bit ok;
        exp_q.delete();
        busy_len[0] = 4;
        feed(0, 8'h0D);
        feed(0, 8'h42);
        drain(0, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cr_done got timeout want idle"); end
        checks++; if (n_pop[0] - bp !== 2) begin errors++; $display("FAIL cr_pops got %0d want 2", n_pop[0] - bp); end
        checks++; if (n_sent[0] - bs !== 3) begin errors++; $display("FAIL cr_sends got %0d want 3", n_sent[0] - bs); end
        checks++; if (seq_diff(0, bs) !== 0) begin errors++; $display("FAIL cr_seq got %0d bad bytes want 0", seq_diff(0, bs)); end
        checks++; if (byte_cnt[0] !== exp_cnt[0]) begin errors++; $display("FAIL cr_cnt got %h want %h", byte_cnt[0], exp_cnt[0]); end
    endtask

    task automatic test_no_lf_and_wrap();
        int bs = n_sent[1];
        bit ok;
        exp_q.delete();
        busy_len[1] = 3;
        feed(1, 8'h0D);
        drain(1, 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nolf_done got timeout want idle"); end
        checks++; if (n_sent[1] - bs !== 1) begin errors++; $display("FAIL nolf_sends got %0d want 1", n_sent[1] - bs); end
        checks++; if (seq_diff(1, bs) !== 0) begin errors++; $display("FAIL nolf_data got %h want 0d", sent[1][bs % 1024]); end
        checks++; if (byte_cnt[1] !== 16'hFFFF) begin errors++; $display("FAIL nolf_cnt got %h want ffff", byte_cnt[1]); end
        feed(1, 8'h33);
        drain(1, 500, ok);
        checks++; if (byte_cnt[1] !== 16'h0000) begin errors++; $display("FAIL wrap_cnt got %h want 0000", byte_cnt[1]); end
    endtask

    task automatic test_timeout();
        bit ok;
        exp_q.delete();
        busy_len[0] = 0;
        feed(0, 8'h11);
        feed(0, 8'h22);
        drain(0, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_done got hang want idle"); end
        checks++; if (last_gap[0] !== BUSY_TO + 5) begin errors++; $display("FAIL timeout_gap got %0d want %0d", last_gap[0], BUSY_TO + 5); end
        checks++; if (byte_cnt[0] !== exp_cnt[0]) begin errors++; $display("FAIL timeout_cnt got %h want %h", byte_cnt[0], exp_cnt[0]); end
    endtask

    task automatic test_enable_drop();
        int bs = n_sent[0];
        int bp;
        int n = 0;
        bit ok;
        exp_q.delete();
        busy_len[0] = 6;
        enable[0] = 1'b1;
        feed(0, 8'h0D);
        while (n_sent[0] == bs && n < 200) begin @(negedge clk); n++; end
        enable[0] = 1'b0;
        drain(0, 500, ok);
        checks++; if (n_sent[0] - bs !== 2) begin errors++; $display("FAIL endrop_finish got %0d sends want 2", n_sent[0] - bs); end
        bp = n_pop[0];
        feed(0, 8'h77);
        repeat (30) @(negedge clk);
        checks++; if (n_pop[0] - bp !== 0) begin errors++; $display("FAIL endrop_hold got %0d pops want 0", n_pop[0] - bp); end
        enable[0] = 1'b1;
        drain(0, 500, ok);
        checks++; if (seq_diff(0, bs) !== 0 || n_sent[0] - bs !== 3) begin errors++; $display("FAIL endrop_seq got %0d sends want 3 matching", n_sent[0] - bs); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2; i++) begin
            int bs = n_sent[i];
            int bp = n_pop[i];
            bit ok;
            logic [7:0] b;
            exp_q.delete();
            busy_len[i] = $urandom_range(1, 12);
            for (int k = 0; k < 24; k++) begin
                b = ($urandom_range(0, 3) == 0) ? 8'h0D : 8'($urandom_range(0, 255));
                feed(i, b);
            end
            for (int c = 0; c < 200; c++) begin
                enable[i] = ($urandom_range(0, 3) != 0);
                @(negedge clk);
            end
            enable[i] = 1'b1;
            drain(i, 5000, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_done[%0d] got timeout want idle", i); end
            checks++; if (n_pop[i] - bp !== 24) begin errors++; $display("FAIL rand_pops[%0d] got %0d want 24", i, n_pop[i] - bp); end
            checks++; if (n_sent[i] - bs !== exp_q.size()) begin errors++; $display("FAIL rand_sends[%0d] got %0d want %0d", i, n_sent[i] - bs, exp_q.size()); end
            checks++; if (seq_diff(i, bs) !== 0) begin errors++; $display("FAIL rand_seq[%0d] got %0d bad bytes want 0", i, seq_diff(i, bs)); end
            checks++; if (byte_cnt[i] !== exp_cnt[i]) begin errors++; $display("FAIL rand_cnt[%0d] got %h want %h", i, byte_cnt[i], exp_cnt[i]); end
            checks++; if (min_gap[i] < 5) begin errors++; $display("FAIL rand_spacing[%0d] got %0d want >=5", i, min_gap[i]); end
            checks++; if (viol[i] !== 0) begin errors++; $display("FAIL rand_empty_pop[%0d] got %0d want 0", i, viol[i]); end
        end
    endtask

    task automatic test_reset_midflight();
        int bs = n_sent[0];
        int bp = n_pop[0];
        int n = 0;
        bit ok;
        exp_q.delete();
        busy_len[0] = 0;
        enable[0] = 1'b1;
        feed(0, 8'h55);
        while (n_sent[0] == bs && n < 200) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (tx_data[0] !== 8'h00 || byte_cnt[0] !== 16'h0000) begin errors++; $display("FAIL rstmid_regs got %h/%h want 00/0000", tx_data[0], byte_cnt[0]); end
        checks++; if (active[0] !== 1'b0 || tx_send[0] !== 1'b0 || read_en[0] !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got %b%b%b want 000", active[0], tx_send[0], read_en[0]); end
        exp_cnt[0] = 16'h0000;
        exp_cnt[1] = 16'hFFFE;
        feed(0, 8'h66);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (read_en[0] !== 1'b0) begin errors++; $display("FAIL rstmid_first_edge got %b want 0", read_en[0]); end
        drain(0, 500, ok);
        checks++; if (n_pop[0] - bp !== 2) begin errors++; $display("FAIL rstmid_pops got %0d want 2", n_pop[0] - bp); end
        checks++; if (seq_diff(0, bs) !== 0 || n_sent[0] - bs !== 2) begin errors++; $display("FAIL rstmid_seq got %0d sends want 2 matching", n_sent[0] - bs); end
        checks++; if (byte_cnt[0] !== 16'h0001) begin errors++; $display("FAIL rstmid_cnt got %h want 0001", byte_cnt[0]); end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single_byte();
        test_cr_insert();
        test_no_lf_and_wrap();
        test_timeout();
        test_enable_drop();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_tx_drain.md
FIFO_TX_DRAIN -- requirements
Module: fifo_tx_drain

Interface
REQ-001 SHALL have parameter ADD_LF, default 1: when 1, every drained 0x0D is followed by an inserted 0x0A.
REQ-002 SHALL have parameter BUSY_TO, default 16: the number of cycles to wait for tx_busy to rise after a send pulse.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  drain permitted while high.
REQ-006 SHALL have port fifo_empty  input  1  FIFO holds no data.
REQ-007 SHALL have port fifo_data  input  8  FIFO read data, valid exactly one cycle after read_en.
REQ-008 SHALL have port tx_busy  input  1  transmitter busy.
REQ-009 SHALL have port read_en  output  1  single-cycle FIFO pop strobe.
REQ-010 SHALL have port tx_data  output  8  byte presented to the transmitter.
REQ-011 SHALL have port tx_send  output  1  single-cycle transmit start pulse.
REQ-012 SHALL have port byte_cnt  output  16  total bytes sent, including inserted LF bytes.
REQ-013 SHALL have port active  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, POP, CAPTURE, SEND, WAIT_HI, WAIT_LO, INSERT.
REQ-015 IDLE: when enable=1, fifo_empty=0 and tx_busy=0, SHALL go to POP.
REQ-016 POP: SHALL drive read_en=1 for exactly one cycle, then go to CAPTURE.
REQ-017 CAPTURE: SHALL register fifo_data into tx_data, then go to SEND.
REQ-018 SEND: SHALL drive tx_send=1 for exactly one cycle with tx_data stable, increment byte_cnt, then go to WAIT_HI.
REQ-019 WAIT_HI: SHALL go to WAIT_LO on tx_busy=1, or after BUSY_TO cycles without tx_busy=1 (timeout).
REQ-020 WAIT_LO: on tx_busy=0, SHALL go to INSERT if ADD_LF=1, the last byte sent was 0x0D and no LF is already pending; otherwise SHALL go to IDLE.
REQ-021 INSERT: SHALL load tx_data=0x0A, mark the LF as sent, then go to SEND; read_en SHALL NOT assert for the inserted byte.
REQ-022 An inserted 0x0A SHALL NOT itself trigger a further insertion.
REQ-023 tx_data SHALL hold its value from CAPTURE or INSERT until the next CAPTURE or INSERT.
REQ-024 read_en SHALL never assert while fifo_empty=1 in the same cycle; if fifo_empty=1 on entry to POP, the block SHALL return to IDLE without popping.
REQ-025 Deasserting enable mid-byte SHALL NOT abort the byte; the block SHALL finish through WAIT_LO (including any pending LF) before stopping in IDLE.
REQ-026 byte_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-027 There SHALL be at most one outstanding byte; a new pop SHALL occur only after the previous byte completes WAIT_LO.
REQ-028 Minimum spacing between consecutive read_en pulses SHALL be 5 cycles.

Reset
REQ-029 When reset=0, asynchronously: state=IDLE, read_en=0, tx_send=0, tx_data=0x00, byte_cnt=0, active=0, LF-pending flag and timeout counter cleared.
REQ-030 Reset asserted mid-transfer SHALL discard the in-flight byte; no tx_send pulse SHALL occur before the next pop after release.
REQ-031 After reset release, the first read_en SHALL occur no earlier than the second rising clk edge.

Verification
REQ-032 Single byte: FIFO holds 0x41, enable=1, tx_busy modelled high for 10 cycles after tx_send -> one read_en, tx_data=0x41, one tx_send, byte_cnt=1, return to IDLE.
REQ-033 CR insertion: FIFO holds 0x0D, 0x42 -> sent sequence 0x0D, 0x0A, 0x42; exactly 2 read_en pulses; byte_cnt=3.
REQ-034 ADD_LF=0: FIFO holds 0x0D -> only 0x0D sent; byte_cnt=1.
REQ-035 Busy timeout: tx_busy held 0 throughout, BUSY_TO=16 -> next pop occurs after 16 cycles in WAIT_HI; no hang.
REQ-036 Reset mid-WAIT_HI: reset=0 for 1 cycle -> all outputs return to reset values immediately; FIFO drain resumes cleanly after release.
REQ-037 Empty and wrap: fifo_empty=1 -> read_en never asserts; preload byte_cnt path through 65536 sends -> byte_cnt=0x0000.
